mips_exec_ctrl: RTL and testbench

//  Execution controller for the single-cycle MIPS datapath. Conditions raw board buttons

---
 rtl/mips_exec_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mips_exec_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl: run/step/breakpoint controller for a single-cycle MIPS datapath.
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   step_btn, run_btn   raw board buttons (async, active-high)
//   bp_en, bp_addr, pc  PC breakpoint enable, breakpoint address, current PC
//   cpu_en              datapath clock-enable; one instruction retires per high cycle
//   halted              1 whenever state != RUN
//   state               HALT=0, STEP=1, RUN=2, BRK=3
//   bp_hit              sticky: execution stopped on the breakpoint
//   instr_count         retired-instruction count (wraps)
//
// mips_btn_cond (per button): 2-FF synchronizer -> debounce -> 1-cycle press pulse.
//   clk_i, rst_ni, btn_i (raw), press_o (registered press pulse)

module mips_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q, db_q, db_prev_q, press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive cycles the synced value has disagreed with the
  // debounced level; any agreement reloads it, so glitches never accumulate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      if (sync2_q != db_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;
endmodule

module mips_exec_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PC_W            = 32,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_btn,
  input  logic             run_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);
  localparam int NUM_BTN = 2;  // [0]=step, [1]=run

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2,
    S_BRK  = 2'd3
  } state_e;

  logic [NUM_BTN-1:0] btn_raw, btn_press;
  logic               step_press, run_press;

  assign btn_raw = {run_btn, step_btn};

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      mips_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .btn_i   (btn_raw[g]),
        .press_o (btn_press[g])
      );
    end
  endgenerate

  assign step_press = btn_press[0];
  assign run_press  = btn_press[1];

  state_e           state_q, state_d;
  logic             bp_hit_q, bp_hit_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q;
  logic             bp_match, bp_stop;

  assign bp_match = bp_en && (pc == bp_addr);
  // first_q masks the breakpoint on the cycle RUN is entered, so resuming
  // from BRK retires the instruction sitting at bp_addr instead of re-trapping.
  assign bp_stop  = bp_match && !first_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_HALT;
      bp_hit_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bp_hit_q <= bp_hit_d;
      first_q  <= first_d;
    end
  end

  // Next state: run press always outranks step press.
  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    case (state_q)
      S_HALT: begin
        if (run_press)       state_d = S_RUN;
        else if (step_press) state_d = S_STEP;
      end
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (run_press) begin
          state_d = S_HALT;
        end else if (bp_stop) begin
          state_d  = S_BRK;
          bp_hit_d = 1'b1;
        end
      end
      S_BRK: begin
        if (run_press) begin
          state_d  = S_RUN;
          bp_hit_d = 1'b0;
        end else if (step_press) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end
      end
      default: state_d = S_HALT;
    endcase
    first_d = (state_d == S_RUN) && (state_q != S_RUN);
  end

  // Outputs: cpu_en is combinational so reset removes it without waiting for an edge.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      S_STEP:  cpu_en = 1'b1;
      S_RUN:   cpu_en = !bp_stop && !run_press;
      default: cpu_en = 1'b0;
    endcase
    halted = (state_q != S_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt_q <= '0;
    else if (cpu_en) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign state       = state_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Bench for mips_exec_ctrl: directed scenarios plus randomized buttons/breakpoints,
// every cycle compared against a behavioural model of the controller.
module tb_mips_exec_ctrl;
  localparam int DB  = 4;
  localparam int CW  = 8;   // narrow counter so wrap-around is reachable
  localparam int CNT_MASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          step_btn, run_btn, bp_en;
  logic [31:0]   bp_addr, pc;
  logic          cpu_en, halted, bp_hit;
  logic [1:0]    state;
  logic [CW-1:0] instr_count;

  int vectors = 0;
  int errors  = 0;

  mips_exec_ctrl #(.DEBOUNCE_CYCLES(DB), .PC_W(32), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .step_btn    (step_btn),
    .run_btn     (run_btn),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .state       (state),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Buttons: the synced value is the raw sample two edges back; the debounced
  // level flips once the last DB synced samples all disagree with it; a press
  // is reported one edge after the debounced level rises.
  int        m_st, m_cnt;
  bit        m_bphit, m_first, m_en, m_bpm;
  bit        m_s1[2], m_s2[2], m_db[2], m_dbp[2], m_pr[2];
  bit [15:0] m_hist[2];
  int        m_nv[2];

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_bphit = 0; m_first = 0; m_en = 0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_pr[b] = 0;
      m_hist[b] = '0; m_nv[b] = 0;
    end
  endtask

  task automatic btn_step(input bit raw, inout bit s1, inout bit s2, inout bit db,
                          inout bit dbp, inout bit pr, inout bit [15:0] hist, inout int nv);
    bit npr, all;
    npr  = db & ~dbp;
    dbp  = db;
    hist = {hist[14:0], s2};
    if (nv < 16) nv++;
    all = 1;
    for (int k = 0; k < DB; k++) if (hist[k] == db) all = 0;
    if (nv >= DB && all) db = ~db;
    s2 = s1;
    s1 = raw;
    pr = npr;
  endtask

  task automatic model_comb();
    m_bpm = bp_en && (pc == bp_addr);
    m_en  = (m_st == 1) || (m_st == 2 && !(m_bpm && !m_first) && !m_pr[1]);
  endtask

  task automatic model_edge();
    int nst;
    nst = m_st;
    if (m_en) m_cnt = (m_cnt + 1) & CNT_MASK;
    case (m_st)
      0: if (m_pr[1]) nst = 2; else if (m_pr[0]) nst = 1;
      1: nst = 0;
      2: if (m_pr[1]) nst = 0;
         else if (m_bpm && !m_first) begin nst = 3; m_bphit = 1; end
      default: if (m_pr[1]) begin nst = 2; m_bphit = 0; end
               else if (m_pr[0]) begin nst = 1; m_bphit = 0; end
    endcase
    m_first = (nst == 2) && (m_st != 2);
    m_st    = nst;
    btn_step(step_btn, m_s1[0], m_s2[0], m_db[0], m_dbp[0], m_pr[0], m_hist[0], m_nv[0]);
    btn_step(run_btn,  m_s1[1], m_s2[1], m_db[1], m_dbp[1], m_pr[1], m_hist[1], m_nv[1]);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit last_en, saw_step;

  // Called at a falling edge with inputs set: compare, clock once, advance pc on retire.
  task automatic tick();
    #1;
    model_comb();
    check("cpu_en",      64'(cpu_en),      64'(m_en));
    check("halted",      64'(halted),      64'(m_st != 2));
    check("state",       64'(state),       64'(m_st));
    check("bp_hit",      64'(bp_hit),      64'(m_bphit));
    check("instr_count", 64'(instr_count), 64'(m_cnt));
    last_en = cpu_en;
    if (state == 2'd1) saw_step = 1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_en) pc = pc + 32'd4;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_cpu_en", 64'(cpu_en),      64'd0);
    check("rst_state",  64'(state),       64'd0);
    check("rst_count",  64'(instr_count), 64'd0);
    check("rst_bp_hit", 64'(bp_hit),      64'd0);
    check("rst_halted", 64'(halted),      64'd1);
    model_reset();
    pc = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic press(input bit is_run, input int hold);
    if (is_run) run_btn = 1'b1; else step_btn = 1'b1;
    ticks(hold);
    if (is_run) run_btn = 1'b0; else step_btn = 1'b0;
  endtask

  // Bounded wait for the model to reach a state.
  task automatic run_until(input int st, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (m_st == st) break;
    end
  endtask

  initial begin
    int first_on, en_cycles;
    reset_n = 1'b0; step_btn = 0; run_btn = 0; bp_en = 0; bp_addr = '0; pc = '0;
    model_reset();
    #2;
    check("init_state",  64'(state),       64'd0);
    check("init_cpu_en", 64'(cpu_en),      64'd0);
    check("init_count",  64'(instr_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: clean step press. Press pulse after edge 7, STEP entered at edge 8,
    // so cpu_en is first seen on the 9th compare.
    step_btn = 1'b1;
    first_on = -1; en_cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) step_btn = 1'b0;
      tick();
      if (last_en) begin
        en_cycles++;
        if (first_on < 0) first_on = i;
      end
    end
    check("t1_first_en", 64'(first_on), 64'd9);
    check("t1_en_cycles", 64'(en_cycles), 64'd1);
    check("t1_count", 64'(instr_count), 64'd1);

    // 2: glitches shorter than the debounce window never press
    do_reset();
    en_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      step_btn = (i % 3 != 2);
      tick();
      if (last_en) en_cycles++;
    end
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (last_en) en_cycles++; end
    check("t2_en_cycles", 64'(en_cycles), 64'd0);
    check("t2_count", 64'(instr_count), 64'd0);

    // 3: run into breakpoint at 0x10
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10;
    press(1, 6);
    run_until(3, 40);
    #1;
    check("t3_state",  64'(state),       64'd3);
    check("t3_bp_hit", 64'(bp_hit),      64'd1);
    check("t3_count",  64'(instr_count), 64'd4);
    check("t3_cpu_en", 64'(cpu_en),      64'd0);

    // 4a: step out of BRK retires exactly the instruction at 0x10
    press(0, 6);
    ticks(8);
    check("t4_step_count", 64'(instr_count), 64'd5);
    check("t4_step_state", 64'(state),       64'd0);
    check("t4_step_bphit", 64'(bp_hit),      64'd0);
    // 4b: trap at 0x20, then resume: the instruction at 0x20 retires
    bp_addr = 32'h20;
    press(1, 6);
    run_until(3, 40);
    check("t4_brk_count", 64'(instr_count), 64'd8);
    press(1, 6);
    ticks(6);
    check("t4_run_state", 64'(state),  64'd2);
    check("t4_run_bphit", 64'(bp_hit), 64'd0);
    check("t4_run_progress", 64'(instr_count > 8'd9), 64'd1);
    press(1, 6);
    ticks(6);
    check("t4_halt_state", 64'(state), 64'd0);

    // 5: simultaneous presses in HALT -> RUN, STEP never visited
    do_reset();
    bp_en = 1'b0;
    saw_step = 0;
    step_btn = 1'b1; run_btn = 1'b1;
    ticks(6);
    step_btn = 1'b0; run_btn = 1'b0;
    ticks(6);
    check("t5_saw_step", 64'(saw_step), 64'd0);
    check("t5_state",    64'(state),    64'd2);
    press(1, 6);
    ticks(6);
    check("t5_halt", 64'(state), 64'd0);

    // 6: reset while running, then counter wrap via breakpoint at count 255
    press(1, 6);
    ticks(4);
    #1;
    check("t6_running", 64'(cpu_en), 64'd1);
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h3FC;
    press(1, 6);
    run_until(3, 320);
    check("t6_pre_wrap", 64'(instr_count), 64'd255);
    press(0, 6);
    ticks(6);
    check("t6_wrap", 64'(instr_count), 64'd0);
    check("t6_wrap_state", 64'(state), 64'd0);

    // Randomized phase
    bp_en = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)  step_btn = ~step_btn;
      if ($urandom_range(0, 11) == 0) run_btn  = ~run_btn;
      if ($urandom_range(0, 19) == 0) bp_en    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bp_addr  = pc + 32'(4 * $urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) pc       = $urandom;
      tick();
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
